// File: rtl/dual_port_ram_if.sv
// Bus bundle for the two independent ports of dual_port_ram.
// The master drives address, write data and write enable; the slave returns registered read data.
interface dual_port_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] add_a;
  logic [DATA_WIDTH-1:0] din_a;
  logic                  we_a;
  logic [DATA_WIDTH-1:0] dout_a;
  logic [ADDR_WIDTH-1:0] add_b;
  logic [DATA_WIDTH-1:0] din_b;
  logic                  we_b;
  logic [DATA_WIDTH-1:0] dout_b;

  modport master (
    output add_a, din_a, we_a,
    output add_b, din_b, we_b,
    input  dout_a, dout_b
  );

  modport slave (
    input  add_a, din_a, we_a,
    input  add_b, din_b, we_b,
    output dout_a, dout_b
  );
endinterface

// File: rtl/dual_port_ram.sv
// True dual-port RAM, write-first per port, port A wins same-address write collisions, 1-cycle read.
// Define RAM_RESET_CLEAR_EN to clear the whole array while rst is low; otherwise only dout is cleared.
module dual_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  dual_port_ram_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Port B is written first so a same-address port A write overrides it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
`ifdef RAM_RESET_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
`endif
    end else begin
      if (bus.we_b) begin
        mem[bus.add_b] <= bus.din_b;
      end
      if (bus.we_a) begin
        mem[bus.add_a] <= bus.din_a;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.dout_a <= '0;
    end else if (bus.we_a) begin
      bus.dout_a <= bus.din_a;
    end else begin
      bus.dout_a <= mem[bus.add_a];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.dout_b <= '0;
    end else if (bus.we_b) begin
      bus.dout_b <= bus.din_b;
    end else begin
      bus.dout_b <= mem[bus.add_b];
    end
  end
endmodule

// File: tb/tb_dual_port_ram.sv
// Directed self-checking bench for dual_port_ram; outputs are sampled 1 time unit after each rising edge.
module tb_dual_port_ram;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  dual_port_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  dual_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.add_a = 8'h44; bus.din_a = 8'h99; bus.we_a = 1'b1;
    bus.add_b = 8'h45; bus.din_b = 8'h77; bus.we_b = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst_dout_a_async", bus.dout_a, 8'h00);
    check("rst_dout_b_async", bus.dout_b, 8'h00);
    tick();
    tick();
    check("rst_dout_a_held", bus.dout_a, 8'h00);
    check("rst_dout_b_held", bus.dout_b, 8'h00);

    // Fill: A writes 3*i at 0..7, B writes 5*j at 8..15 concurrently.
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.we_a = 1'b1; bus.add_a = 8'(i);     bus.din_a = 8'(3 * i);
      bus.we_b = 1'b1; bus.add_b = 8'(i + 8); bus.din_b = 8'(5 * (i + 8));
      tick();
    end
    check("fill_wf_a", bus.dout_a, 8'd21);
    check("fill_wf_b", bus.dout_b, 8'd75);

    bus.we_a = 1'b0; bus.we_b = 1'b0;
    bus.add_a = 8'd3; bus.add_b = 8'd8;
    tick();
    check("rd_a_3", bus.dout_a, 8'd9);
    check("rd_b_8", bus.dout_b, 8'd40);
    bus.add_a = 8'd7; bus.add_b = 8'd15;
    tick();
    check("rd_a_7", bus.dout_a, 8'd21);
    check("rd_b_15", bus.dout_b, 8'd75);
    bus.add_a = 8'd12; bus.add_b = 8'd0;
    tick();
    check("rd_a_12_crossfill", bus.dout_a, 8'd60);
    check("rd_b_0_crossfill", bus.dout_b, 8'd0);

    // Write-first on A, then B sees the new word.
    bus.we_a = 1'b1; bus.add_a = 8'd20; bus.din_a = 8'hAB;
    tick();
    check("wf_a_20", bus.dout_a, 8'hAB);
    bus.we_a = 1'b0; bus.add_b = 8'd20;
    tick();
    check("wf_b_20", bus.dout_b, 8'hAB);

    // Cross-port: B reads old value on the write edge, new value one edge later.
    bus.we_a = 1'b1; bus.add_a = 8'd5; bus.din_a = 8'h55; bus.add_b = 8'd5;
    tick();
    check("cross_b_old", bus.dout_b, 8'd15);
    check("cross_a_wf", bus.dout_a, 8'h55);
    bus.we_a = 1'b0;
    tick();
    check("cross_b_new", bus.dout_b, 8'h55);

    // Symmetric cross-port: B writes, A reads the old value first.
    bus.we_b = 1'b1; bus.add_b = 8'd6; bus.din_b = 8'h66; bus.add_a = 8'd6;
    tick();
    check("cross_a_old", bus.dout_a, 8'd18);
    bus.we_b = 1'b0;
    tick();
    check("cross_a_new", bus.dout_a, 8'h66);

    // Same-address write collision: A wins the array, each dout shows its own din.
    bus.we_a = 1'b1; bus.add_a = 8'd30; bus.din_a = 8'h11;
    bus.we_b = 1'b1; bus.add_b = 8'd30; bus.din_b = 8'h22;
    tick();
    check("coll_wf_a", bus.dout_a, 8'h11);
    check("coll_wf_b", bus.dout_b, 8'h22);
    bus.we_a = 1'b0; bus.we_b = 1'b0;
    tick();
    check("coll_rd_a", bus.dout_a, 8'h11);
    check("coll_rd_b", bus.dout_b, 8'h11);

    // Reset mid-operation with a pending write to addr 3.
    bus.we_a = 1'b1; bus.add_a = 8'd3; bus.din_a = 8'hEE;
    bus.we_b = 1'b1; bus.add_b = 8'd10; bus.din_b = 8'hDD;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_a_async", bus.dout_a, 8'h00);
    check("mid_rst_b_async", bus.dout_b, 8'h00);
    tick();
    check("mid_rst_a_held", bus.dout_a, 8'h00);
    check("mid_rst_b_held", bus.dout_b, 8'h00);
    rst = 1'b1;
    bus.we_a = 1'b0; bus.we_b = 1'b0;
    bus.add_a = 8'd3; bus.add_b = 8'd10;
    tick();
`ifdef RAM_RESET_CLEAR_EN
    check("post_rst_a_3", bus.dout_a, 8'h00);
    check("post_rst_b_10", bus.dout_b, 8'h00);
`else
    check("post_rst_a_3", bus.dout_a, 8'd9);
    check("post_rst_b_10", bus.dout_b, 8'd50);
`endif
    bus.add_a = 8'd30; bus.add_b = 8'd20;
    tick();
`ifdef RAM_RESET_CLEAR_EN
    check("post_rst_a_30", bus.dout_a, 8'h00);
    check("post_rst_b_20", bus.dout_b, 8'h00);
`else
    check("post_rst_a_30", bus.dout_a, 8'h11);
    check("post_rst_b_20", bus.dout_b, 8'hAB);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
